// File: rtl/packet_demux_pd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : packet_demux_pd_pkg
// Description : Shared types and constants for the packet_demux_pd egress stage.
// Revision    : 1.0 - initial release
// ============================================================================
package packet_demux_pd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PKT  = 2'd1,
    DROP = 2'd2
  } state_t;

  localparam int MAX_PORTS        = 16;
  localparam int BEAT_DATA_WIDTH  = 8;
  localparam int BEAT_EMPTY_WIDTH = 1;
  localparam int BEAT_ERROR_WIDTH = 1;
  localparam int BEAT_TS_WIDTH    = 8;

  // Reference beat layout at the default widths; the top re-declares it with its own parameters.
  typedef struct packed {
    logic                        sop;
    logic                        eop;
    logic [BEAT_ERROR_WIDTH-1:0] error;
    logic [BEAT_EMPTY_WIDTH-1:0] empty;
    logic [BEAT_DATA_WIDTH-1:0]  data;
    logic                        ts_valid;
    logic [BEAT_TS_WIDTH-1:0]    ts_data;
  } beat_t;

endpackage
`default_nettype wire

// File: rtl/avst_reg_slice.sv
`default_nettype none
// ============================================================================
// Module      : avst_reg_slice
// Description : One-deep full-throughput valid/ready register with stable hold.
// Revision    : 1.0 - initial release
// ============================================================================
module avst_reg_slice #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_payload,
  input  logic             i_ready,
  output logic             o_slot_rdy,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_payload
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] payload_q, payload_d;

  assign o_slot_rdy = !valid_q || i_ready;
  assign o_valid    = valid_q;
  assign o_payload  = payload_q;

  // Callers only assert i_load when o_slot_rdy is high, so a held beat is never overwritten.
  always_comb begin
    valid_d   = valid_q;
    payload_d = payload_q;
    if (i_load) begin
      valid_d   = 1'b1;
      payload_d = i_payload;
    end else if (i_ready) begin
      valid_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/packet_demux_pd.sv
`default_nettype none
// ============================================================================
// Module      : packet_demux_pd
// Description : Steers whole channel-tagged AVST packets to per-port register
//               slices; drops orphan/out-of-range traffic. Optional statistics
//               counters enabled by PACKET_DEMUX_PD_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module packet_demux_pd
  import packet_demux_pd_pkg::*;
#(
  parameter int NUM_PORTS     = 8,
  parameter int CHANNEL_WIDTH = 3,
  parameter int DATA_WIDTH    = 8,
  parameter int EMPTY_WIDTH   = 1,
  parameter int ERROR_WIDTH   = 1,
  parameter int TS_DATA_WIDTH = 8,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     i_avst_ready,
  input  logic                     i_avst_valid,
  input  logic                     i_avst_startofpacket,
  input  logic                     i_avst_endofpacket,
  input  logic [CHANNEL_WIDTH-1:0] i_avst_channel,
  input  logic [ERROR_WIDTH-1:0]   i_avst_error,
  input  logic [EMPTY_WIDTH-1:0]   i_avst_empty,
  input  logic [DATA_WIDTH-1:0]    i_avst_data,
  input  logic                     i_ts_valid,
  input  logic [TS_DATA_WIDTH-1:0] i_ts_data,
  input  logic [NUM_PORTS-1:0]     o_avst_ready,
  output logic [NUM_PORTS-1:0]     o_avst_valid,
  output logic [NUM_PORTS-1:0]     o_avst_startofpacket,
  output logic [NUM_PORTS-1:0]     o_avst_endofpacket,
  output logic [ERROR_WIDTH-1:0]   o_avst_error [NUM_PORTS],
  output logic [EMPTY_WIDTH-1:0]   o_avst_empty [NUM_PORTS],
  output logic [DATA_WIDTH-1:0]    o_avst_data  [NUM_PORTS],
  output logic [NUM_PORTS-1:0]     o_ts_valid,
  output logic [TS_DATA_WIDTH-1:0] o_ts_data    [NUM_PORTS],
  output logic [CNT_WIDTH-1:0]     o_drop_cnt,
  output logic [CNT_WIDTH-1:0]     o_trunc_cnt
);

  typedef struct packed {
    logic                     sop;
    logic                     eop;
    logic [ERROR_WIDTH-1:0]   error;
    logic [EMPTY_WIDTH-1:0]   empty;
    logic [DATA_WIDTH-1:0]    data;
    logic                     ts_valid;
    logic [TS_DATA_WIDTH-1:0] ts_data;
  } pd_beat_t;

  localparam int                     BEAT_W      = $bits(pd_beat_t);
  localparam logic [CHANNEL_WIDTH:0] C_NUM_PORTS = (CHANNEL_WIDTH + 1)'(NUM_PORTS);

  state_t                   state_q, state_d;
  logic [CHANNEL_WIDTH-1:0] route_q, route_d;
  logic [CHANNEL_WIDTH-1:0] tgt;
  logic [NUM_PORTS-1:0]     slot_rdy, load;
  logic                     fwd, tgt_rdy, in_range, accept;
  pd_beat_t                 beat_in;

  assign in_range = {1'b0, i_avst_channel} < C_NUM_PORTS;
  assign beat_in  = {i_avst_startofpacket, i_avst_endofpacket, i_avst_error,
                     i_avst_empty, i_avst_data, i_ts_valid, i_ts_data};

  // An SOP always re-routes, whatever state we are in; mid-packet beats follow the latched route.
  always_comb begin
    fwd = 1'b0;
    tgt = route_q;
    if (i_avst_startofpacket) begin
      fwd = in_range;
      tgt = i_avst_channel;
    end else if (state_q == PKT) begin
      fwd = 1'b1;
    end
  end

  always_comb begin
    tgt_rdy = 1'b0;
    load    = '0;
    for (int n = 0; n < NUM_PORTS; n++) begin
      if (tgt == CHANNEL_WIDTH'(n)) begin
        tgt_rdy = slot_rdy[n];
        load[n] = accept && fwd;
      end
    end
  end

  assign i_avst_ready = !rst && (fwd ? tgt_rdy : 1'b1);
  assign accept       = i_avst_valid && i_avst_ready;

  always_comb begin
    state_d = state_q;
    route_d = route_q;
    if (accept) begin
      if (i_avst_startofpacket) begin
        route_d = i_avst_channel;
        if (i_avst_endofpacket) state_d = IDLE;
        else                    state_d = in_range ? PKT : DROP;
      end else if (i_avst_endofpacket) begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      route_q <= '0;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
    end
  end

  for (genvar n = 0; n < NUM_PORTS; n++) begin : g_port
    pd_beat_t beat_out;

    avst_reg_slice #(.WIDTH(BEAT_W)) u_slice (
      .clk        (clk),
      .rst        (rst),
      .i_load     (load[n]),
      .i_payload  (beat_in),
      .i_ready    (o_avst_ready[n]),
      .o_slot_rdy (slot_rdy[n]),
      .o_valid    (o_avst_valid[n]),
      .o_payload  (beat_out)
    );

    assign o_avst_startofpacket[n] = beat_out.sop;
    assign o_avst_endofpacket[n]   = beat_out.eop;
    assign o_avst_error[n]         = beat_out.error;
    assign o_avst_empty[n]         = beat_out.empty;
    assign o_avst_data[n]          = beat_out.data;
    assign o_ts_valid[n]           = o_avst_valid[n] && beat_out.ts_valid;
    assign o_ts_data[n]            = beat_out.ts_data;
  end

`ifdef PACKET_DEMUX_PD_STATS_EN
  logic                 drop, trunc;
  logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d, trunc_cnt_q, trunc_cnt_d;

  assign drop  = accept && !fwd;
  assign trunc = accept && i_avst_startofpacket && (state_q != IDLE);

  // Both counters stick at all-ones rather than wrapping.
  always_comb begin
    drop_cnt_d  = drop_cnt_q;
    trunc_cnt_d = trunc_cnt_q;
    if (drop && (drop_cnt_q != '1))   drop_cnt_d  = drop_cnt_q + 1'b1;
    if (trunc && (trunc_cnt_q != '1)) trunc_cnt_d = trunc_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_q  <= '0;
      trunc_cnt_q <= '0;
    end else begin
      drop_cnt_q  <= drop_cnt_d;
      trunc_cnt_q <= trunc_cnt_d;
    end
  end

  assign o_drop_cnt  = drop_cnt_q;
  assign o_trunc_cnt = trunc_cnt_q;
`else
  assign o_drop_cnt  = '0;
  assign o_trunc_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_packet_demux_pd.sv
`default_nettype none
// ============================================================================
// Module      : tb_packet_demux_pd
// Description : Directed self-checking bench for packet_demux_pd (6 ports, 4-bit counters).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_packet_demux_pd;

  localparam int NP   = 6;
  localparam int CNTW = 4;
`ifdef PACKET_DEMUX_PD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            i_ready;
  logic            ivalid = 1'b0, isop = 1'b0, ieop = 1'b0, itsv = 1'b0;
  logic [2:0]      ich = '0;
  logic [0:0]      ierr = '0, iemp = '0;
  logic [7:0]      idata = '0, its = '0;
  logic [NP-1:0]   o_rdy = '1;
  logic [NP-1:0]   o_valid, o_sop, o_eop, o_tsv;
  logic [0:0]      o_err [NP];
  logic [0:0]      o_emp [NP];
  logic [7:0]      o_data [NP];
  logic [7:0]      o_ts [NP];
  logic [CNTW-1:0] o_drop, o_trunc;

  packet_demux_pd #(
    .NUM_PORTS(NP), .CHANNEL_WIDTH(3), .DATA_WIDTH(8), .EMPTY_WIDTH(1),
    .ERROR_WIDTH(1), .TS_DATA_WIDTH(8), .CNT_WIDTH(CNTW)
  ) dut (
    .clk(clk), .rst(rst), .i_avst_ready(i_ready), .i_avst_valid(ivalid),
    .i_avst_startofpacket(isop), .i_avst_endofpacket(ieop), .i_avst_channel(ich),
    .i_avst_error(ierr), .i_avst_empty(iemp), .i_avst_data(idata),
    .i_ts_valid(itsv), .i_ts_data(its), .o_avst_ready(o_rdy), .o_avst_valid(o_valid),
    .o_avst_startofpacket(o_sop), .o_avst_endofpacket(o_eop), .o_avst_error(o_err),
    .o_avst_empty(o_emp), .o_avst_data(o_data), .o_ts_valid(o_tsv), .o_ts_data(o_ts),
    .o_drop_cnt(o_drop), .o_trunc_cnt(o_trunc)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_cnt(input int v);
    if (!STATS) return 0;
    return (v > 15) ? 15 : v;
  endfunction

  // Model: each port is a queue of beats the sink has not yet taken; routing follows packet rules.
  typedef struct packed {
    logic       sop;
    logic       eop;
    logic       err;
    logic       emp;
    logic [7:0] data;
    logic       tsv;
    logic [7:0] ts;
  } exp_t;

  exp_t       q [NP][$];
  int         mstate = 0;  // 0 idle, 1 in forwarded packet, 2 in dropped packet
  logic [2:0] mroute = '0;
  int         mdrop  = 0;
  int         mtrunc = 0;

  always @(negedge clk) begin
    exp_t       e;
    logic       fwd, erdy;
    logic [2:0] tgt;
    if (rst) begin
      for (int n = 0; n < NP; n++) q[n].delete();
      mstate = 0; mroute = '0; mdrop = 0; mtrunc = 0;
    end
    for (int n = 0; n < NP; n++) begin
      chk($sformatf("valid[%0d]", n), o_valid[n], q[n].size() != 0);
      if (q[n].size() != 0) begin
        e = q[n][0];
        chk($sformatf("data[%0d]", n), o_data[n], e.data);
        chk($sformatf("sop[%0d]", n), o_sop[n], e.sop);
        chk($sformatf("eop[%0d]", n), o_eop[n], e.eop);
        chk($sformatf("err[%0d]", n), o_err[n], e.err);
        chk($sformatf("emp[%0d]", n), o_emp[n], e.emp);
        chk($sformatf("ts_data[%0d]", n), o_ts[n], e.ts);
        chk($sformatf("ts_valid[%0d]", n), o_tsv[n], e.tsv);
      end else begin
        chk($sformatf("ts_valid[%0d]", n), o_tsv[n], 1'b0);
      end
    end
    chk("drop_cnt", o_drop, exp_cnt(mdrop));
    chk("trunc_cnt", o_trunc, exp_cnt(mtrunc));

    fwd = 1'b0;
    tgt = mroute;
    if (isop) begin
      fwd = (ich < NP);
      tgt = ich;
    end else if (mstate == 1) begin
      fwd = 1'b1;
    end
    if (rst)      erdy = 1'b0;
    else if (fwd) erdy = (q[tgt].size() == 0) || o_rdy[tgt];
    else          erdy = 1'b1;
    chk("in_ready", i_ready, erdy);

    if (!rst) begin
      for (int n = 0; n < NP; n++)
        if (q[n].size() != 0 && o_rdy[n]) void'(q[n].pop_front());
      if (ivalid && erdy) begin
        e = {isop, ieop, ierr, iemp, idata, itsv, its};
        if (isop) begin
          if (mstate != 0) mtrunc++;
          if (fwd) q[ich].push_back(e);
          else     mdrop++;
          mroute = ich;
          mstate = ieop ? 0 : (fwd ? 1 : 2);
        end else if (mstate == 1) begin
          q[mroute].push_back(e);
          if (ieop) mstate = 0;
        end else begin
          mdrop++;
          if (ieop) mstate = 0;
        end
      end
    end
  end

  // Drives one beat from posedge+1 and returns at posedge+1 after the handshake edge.
  task automatic send(input logic sop, input logic eop, input logic [2:0] ch,
                      input logic [7:0] d, input logic [7:0] ts);
    bit got = 1'b0;
    ivalid = 1'b1; isop = sop; ieop = eop; ich = ch; idata = d;
    ierr = d[7]; iemp = eop & d[0]; itsv = (ts != 8'h00); its = ts;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      got = i_ready;
      @(posedge clk);
      #1;
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL send_timeout: ch=%0d got no ready want ready within 50 cycles", ch);
    end
    ivalid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int c0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", i_ready, 1'b0);
    chk("rst_valid", o_valid, '0);
    chk("rst_drop", o_drop, '0);
    chk("rst_trunc", o_trunc, '0);
    rst = 1'b0;

    // Back-to-back: 3 beats to port 5 then a single-beat packet to port 2.
    c0 = cyc;
    send(1'b1, 1'b0, 3'd5, 8'h51, 8'h11);
    send(1'b0, 1'b0, 3'd5, 8'h52, 8'h12);
    send(1'b0, 1'b1, 3'd5, 8'h53, 8'h00);
    send(1'b1, 1'b1, 3'd2, 8'hB1, 8'h21);
    chk("b2b_cycles", cyc - c0, 4);
    chk("b2b_p2_valid", o_valid[2], 1'b1);
    chk("b2b_p2_data", o_data[2], 8'hB1);
    chk("b2b_p2_ts", o_ts[2], 8'h21);

    // Mid-packet channel change is ignored; stall on port 5 back-pressures the input.
    send(1'b1, 1'b0, 3'd5, 8'h61, 8'h31);
    o_rdy[5] = 1'b0;
    fork
      begin
        send(1'b0, 1'b0, 3'd1, 8'h62, 8'h32);
        send(1'b0, 1'b1, 3'd1, 8'h63, 8'h33);
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        chk("stall_ready", i_ready, 1'b0);
        chk("stall_p5_data", o_data[5], 8'h61);
        chk("stall_p1_valid", o_valid[1], 1'b0);
        o_rdy[5] = 1'b1;
      end
    join
    repeat (2) @(posedge clk);
    #1;

    // Out-of-range channel 7 with only 6 ports: every beat dropped.
    do_reset();
    send(1'b1, 1'b0, 3'd7, 8'h71, 8'h01);
    send(1'b0, 1'b0, 3'd7, 8'h72, 8'h02);
    send(1'b0, 1'b0, 3'd7, 8'h73, 8'h03);
    send(1'b0, 1'b1, 3'd7, 8'h74, 8'h04);
    chk("oor_valid", o_valid, '0);
    chk("oor_drop", o_drop, STATS ? 4 : 0);

    // Orphan beat, then SOP ch3 truncated by SOP ch0.
    do_reset();
    send(1'b0, 1'b1, 3'd0, 8'h81, 8'h00);
    send(1'b1, 1'b0, 3'd3, 8'h82, 8'h05);
    send(1'b1, 1'b0, 3'd0, 8'h83, 8'h06);
    send(1'b0, 1'b1, 3'd0, 8'h84, 8'h07);
    chk("trunc_drop", o_drop, STATS ? 1 : 0);
    chk("trunc_trunc", o_trunc, STATS ? 1 : 0);
    chk("trunc_p0_valid", o_valid[0], 1'b1);
    chk("trunc_p0_data", o_data[0], 8'h84);

    // Asynchronous reset while port 4 holds a beat.
    do_reset();
    o_rdy[4] = 1'b0;
    send(1'b1, 1'b0, 3'd4, 8'h91, 8'h41);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_p4_valid", o_valid[4], 1'b0);
    chk("arst_ready", i_ready, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    o_rdy[4] = 1'b1;
    send(1'b0, 1'b0, 3'd4, 8'h92, 8'h00);
    chk("arst_orphan_valid", o_valid[4], 1'b0);
    chk("arst_orphan_drop", o_drop, STATS ? 1 : 0);

    // Saturation: 20 orphan beats on a 4-bit counter.
    do_reset();
    for (int k = 0; k < 20; k++) send(1'b0, 1'b0, 3'd3, 8'(k), 8'h00);
    chk("sat_drop", o_drop, STATS ? 15 : 0);
    chk("sat_trunc", o_trunc, 0);

    @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want test completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
